frame_sequencer: RTL and testbench

//  Sequences one image frame through the pixel pipeline: parse -> rgb2gray -> frame buffer -> sobel -> VGA.

---
 rtl/frame_sequencer_if.sv | 30 +++
 rtl/frame_sequencer.sv | 136 +++++++++++++
 tb/tb_frame_sequencer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/frame_sequencer_if.sv
// Handshake/bus bundle between the frame sequencer and the pixel pipeline
// (parse, rgb2gray, frame buffer, sobel, VGA).
interface frame_sequencer_if #(
   parameter int ADDR_W = 17
);
   logic              hdr_valid;
   logic [15:0]       width;
   logic [15:0]       height;
   logic              pix_valid;
   logic [7:0]        gray_in;
   logic              buf_we;
   logic [ADDR_W-1:0] buf_addr;
   logic [7:0]        buf_wdata;
   logic              sobel_start;
   logic              sobel_ready;
   logic              disp_en;
   logic              frame_done;
   logic              busy;
   logic              err;

   modport master (
      output hdr_valid, width, height, pix_valid, gray_in, sobel_ready,
      input  buf_we, buf_addr, buf_wdata, sobel_start, disp_en, frame_done, busy, err
   );

   modport slave (
      input  hdr_valid, width, height, pix_valid, gray_in, sobel_ready,
      output buf_we, buf_addr, buf_wdata, sobel_start, disp_en, frame_done, busy, err
   );
endinterface

// File: rtl/frame_sequencer.sv
// Sequences one frame: header latch, raster pixel writes into the frame buffer,
// sobel kick-off once the frame is complete, then display enable.
module frame_sequencer #(
   parameter int MAX_W  = 320,
   parameter int MAX_H  = 240,
   parameter int ADDR_W = 17
) (
   input logic               clk,
   input logic               reset,
   frame_sequencer_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, LOAD, FILTER, SHOW} state_t;

   localparam logic [15:0] MAX_W16 = 16'(MAX_W);
   localparam logic [15:0] MAX_H16 = 16'(MAX_H);

   state_t            state_q, state_d;
   logic [15:0]       w_q, w_d, h_q, h_d, x_q, x_d, y_q, y_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              buf_we_q, buf_we_d;
   logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
   logic [7:0]        buf_wdata_q, buf_wdata_d;
   logic              sobel_start_q, sobel_start_d;
   logic              disp_en_q, disp_en_d;
   logic              frame_done_q, frame_done_d;
   logic              busy_q, busy_d;
   logic              err_q, err_d;
   logic              hdr_ok;

   assign hdr_ok = (bus.width != 16'd0) && (bus.height != 16'd0) &&
                   (bus.width <= MAX_W16) && (bus.height <= MAX_H16);

   always_comb begin
      state_d     = state_q;
      w_d         = w_q;
      h_d         = h_q;
      x_d         = x_q;
      y_d         = y_q;
      addr_d      = addr_q;
      buf_we_d    = 1'b0;
      buf_addr_d  = buf_addr_q;
      buf_wdata_d = buf_wdata_q;
      err_d       = 1'b0;

      // A header takes priority over everything, including a same-cycle pixel.
      if (bus.hdr_valid) begin
         if (hdr_ok) begin
            w_d     = bus.width;
            h_d     = bus.height;
            x_d     = 16'd0;
            y_d     = 16'd0;
            addr_d  = '0;
            state_d = LOAD;
         end else begin
            err_d   = 1'b1;
            state_d = IDLE;
         end
      end else begin
         case (state_q)
            LOAD: begin
               if (bus.pix_valid) begin
                  buf_we_d    = 1'b1;
                  buf_addr_d  = addr_q;
                  buf_wdata_d = bus.gray_in;
                  if (x_q == w_q - 16'd1) begin
                     x_d = 16'd0;
                     y_d = y_q + 16'd1;
                     if (y_q == h_q - 16'd1) begin
                        // Last pixel: addr stays at w*h-1.
                        state_d = FILTER;
                     end else begin
                        addr_d = addr_q + ADDR_W'(1);
                     end
                  end else begin
                     x_d    = x_q + 16'd1;
                     addr_d = addr_q + ADDR_W'(1);
                  end
               end
            end
            FILTER: begin
               // sobel_start_q marks the first FILTER cycle, where ready is ignored.
               if (!sobel_start_q && bus.sobel_ready) state_d = SHOW;
            end
            default: ;
         endcase
      end

      sobel_start_d = (state_q == LOAD) && (state_d == FILTER);
      frame_done_d  = (state_q != SHOW) && (state_d == SHOW);
      disp_en_d     = (state_d == SHOW);
      busy_d        = (state_d == LOAD) || (state_d == FILTER);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         w_q           <= 16'd0;
         h_q           <= 16'd0;
         x_q           <= 16'd0;
         y_q           <= 16'd0;
         addr_q        <= '0;
         buf_we_q      <= 1'b0;
         buf_addr_q    <= '0;
         buf_wdata_q   <= 8'd0;
         sobel_start_q <= 1'b0;
         disp_en_q     <= 1'b0;
         frame_done_q  <= 1'b0;
         busy_q        <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         w_q           <= w_d;
         h_q           <= h_d;
         x_q           <= x_d;
         y_q           <= y_d;
         addr_q        <= addr_d;
         buf_we_q      <= buf_we_d;
         buf_addr_q    <= buf_addr_d;
         buf_wdata_q   <= buf_wdata_d;
         sobel_start_q <= sobel_start_d;
         disp_en_q     <= disp_en_d;
         frame_done_q  <= frame_done_d;
         busy_q        <= busy_d;
         err_q         <= err_d;
      end
   end

   assign bus.buf_we      = buf_we_q;
   assign bus.buf_addr    = buf_addr_q;
   assign bus.buf_wdata   = buf_wdata_q;
   assign bus.sobel_start = sobel_start_q;
   assign bus.disp_en     = disp_en_q;
   assign bus.frame_done  = frame_done_q;
   assign bus.busy        = busy_q;
   assign bus.err         = err_q;
endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer: directed scenarios plus random traffic, checked every
// cycle against a pixel-count model of the frame flow.
module tb_frame_sequencer;
   localparam int ADDR_W = 17;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   frame_sequencer_if #(.ADDR_W(ADDR_W)) bus();

   frame_sequencer #(.MAX_W(320), .MAX_H(240), .ADDR_W(ADDR_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
      end
   endtask

   // Model: phase 0 idle, 1 loading, 2 filtering, 3 showing.
   int   m_phase = 0;
   int   m_w = 0, m_h = 0, m_k = 0, m_age = 0;
   logic e_we, e_start, e_done, e_err, e_rst;
   int   e_addr, e_data;

   // Observed DUT events, used by the literal pins.
   int cnt_we = 0, cnt_start = 0, cnt_done = 0, cnt_err = 0;
   int wr_addrs[$];
   int wr_data[$];

   always @(posedge clk) begin
      e_we = 1'b0; e_start = 1'b0; e_done = 1'b0; e_err = 1'b0; e_rst = 1'b0;
      if (reset) begin
         m_phase = 0; m_w = 0; m_h = 0; m_k = 0;
         e_rst = 1'b1; e_addr = 0; e_data = 0;
      end else if (bus.hdr_valid) begin
         if (bus.width != 0 && bus.height != 0 && bus.width <= 320 && bus.height <= 240) begin
            m_phase = 1; m_w = int'(bus.width); m_h = int'(bus.height); m_k = 0;
         end else begin
            m_phase = 0; e_err = 1'b1;
         end
      end else if (m_phase == 1 && bus.pix_valid) begin
         e_we = 1'b1; e_addr = m_k; e_data = int'(bus.gray_in);
         m_k++;
         if (m_k == m_w * m_h) begin
            m_phase = 2; m_age = 0; e_start = 1'b1;
         end
      end else if (m_phase == 2) begin
         if (m_age >= 1 && bus.sobel_ready) begin
            m_phase = 3; e_done = 1'b1;
         end else begin
            m_age++;
         end
      end
      #1;
      chk("buf_we", bus.buf_we, e_we);
      if (e_we || e_rst) begin
         chk("buf_addr", bus.buf_addr, e_addr);
         chk("buf_wdata", bus.buf_wdata, e_data);
      end
      chk("sobel_start", bus.sobel_start, e_start);
      chk("frame_done", bus.frame_done, e_done);
      chk("err", bus.err, e_err);
      chk("busy", bus.busy, (m_phase == 1 || m_phase == 2) ? 1 : 0);
      chk("disp_en", bus.disp_en, (m_phase == 3) ? 1 : 0);
      if (bus.buf_we) begin
         cnt_we++;
         wr_addrs.push_back(int'(bus.buf_addr));
         wr_data.push_back(int'(bus.buf_wdata));
      end
      if (bus.sobel_start) cnt_start++;
      if (bus.frame_done)  cnt_done++;
      if (bus.err)         cnt_err++;
   end

   task automatic drive(input logic rst, input logic hv, input int wd, input int ht,
                        input logic pv, input int g, input logic rdy);
      reset           = rst;
      bus.hdr_valid   = hv;
      bus.width       = 16'(wd);
      bus.height      = 16'(ht);
      bus.pix_valid   = pv;
      bus.gray_in     = 8'(g);
      bus.sobel_ready = rdy;
      @(negedge clk);
   endtask

   task automatic idle(input int n, input logic rdy);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0, 1'b0, 0, rdy);
   endtask

   task automatic clear_log();
      wr_addrs.delete();
      wr_data.delete();
   endtask

   int s_we, s_start, s_done, s_err;

   initial begin
      reset = 1'b1;
      bus.hdr_valid = 1'b0; bus.width = 16'd0; bus.height = 16'd0;
      bus.pix_valid = 1'b0; bus.gray_in = 8'd0; bus.sobel_ready = 1'b0;
      @(negedge clk);
      drive(1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b0);
      idle(1, 1'b0);

      // 1: 4x2 frame, gray 0..7
      clear_log(); s_start = cnt_start; s_done = cnt_done;
      drive(1'b0, 1'b1, 4, 2, 1'b0, 0, 1'b0);
      for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, 0, 0, 1'b1, i, 1'b0);
      idle(3, 1'b0);
      chk("t1_writes", wr_addrs.size(), 8);
      chk("t1_last_addr", wr_addrs.size() == 8 ? wr_addrs[7] : -1, 7);
      chk("t1_last_data", wr_data.size() == 8 ? wr_data[7] : -1, 7);
      chk("t1_start_once", cnt_start - s_start, 1);
      chk("t1_busy_filter", bus.busy, 1);
      idle(2, 1'b1);
      chk("t1_disp_en", bus.disp_en, 1);
      chk("t1_done_once", cnt_done - s_done, 1);

      // 2: 3x3, three pixels wrap the first line
      clear_log();
      drive(1'b0, 1'b1, 3, 3, 1'b0, 0, 1'b0);
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 0, 0, 1'b1, 8'h40 + i, 1'b0);
      idle(1, 1'b0);
      chk("t2_addr2", wr_addrs.size() == 3 ? wr_addrs[2] : -1, 2);
      chk("t2_busy", bus.busy, 1);
      chk("t2_disp_off", bus.disp_en, 0);

      // 3: rejected headers from LOAD
      s_err = cnt_err; s_we = cnt_we;
      drive(1'b0, 1'b1, 0, 5, 1'b0, 0, 1'b0);
      drive(1'b0, 1'b1, 321, 10, 1'b0, 0, 1'b0);
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 0, 0, 1'b1, i, 1'b0);
      chk("t3_err_pulses", cnt_err - s_err, 2);
      chk("t3_no_write", cnt_we - s_we, 0);
      chk("t3_idle_busy", bus.busy, 0);

      // 4: sobel_ready high before start, 2x1 frame
      s_done = cnt_done;
      drive(1'b0, 1'b1, 2, 1, 1'b0, 0, 1'b1);
      drive(1'b0, 1'b0, 0, 0, 1'b1, 9, 1'b1);
      drive(1'b0, 1'b0, 0, 0, 1'b1, 10, 1'b1);
      idle(4, 1'b1);
      chk("t4_done_once", cnt_done - s_done, 1);
      chk("t4_disp_en", bus.disp_en, 1);

      // 5: abort with simultaneous header + pixel
      clear_log(); s_start = cnt_start;
      drive(1'b0, 1'b1, 4, 4, 1'b0, 0, 1'b0);
      for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 0, 0, 1'b1, i, 1'b0);
      drive(1'b0, 1'b1, 2, 2, 1'b1, 8'hEE, 1'b0);
      for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 0, 0, 1'b1, 8'h20 + i, 1'b0);
      idle(2, 1'b0);
      chk("t5_writes", wr_addrs.size(), 9);
      chk("t5_restart_addr", wr_addrs.size() > 5 ? wr_addrs[5] : -1, 0);
      chk("t5_restart_data", wr_data.size() > 5 ? wr_data[5] : -1, 8'h20);
      chk("t5_start_once", cnt_start - s_start, 1);

      // 6: reset while in FILTER
      s_done = cnt_done;
      drive(1'b0, 1'b1, 2, 1, 1'b0, 0, 1'b0);
      drive(1'b0, 1'b0, 0, 0, 1'b1, 1, 1'b0);
      drive(1'b0, 1'b0, 0, 0, 1'b1, 2, 1'b0);
      drive(1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b0);
      chk("t6_busy_rst", bus.busy, 0);
      idle(4, 1'b1);
      chk("t6_no_done", cnt_done - s_done, 0);
      chk("t6_disp_off", bus.disp_en, 0);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         int r, wd, ht;
         r = $urandom_range(0, 99);
         wd = $urandom_range(1, 5);
         ht = $urandom_range(1, 4);
         case ($urandom_range(0, 9))
            0: wd = 0;
            1: wd = 321;
            2: ht = 241;
            default: ;
         endcase
         drive(r == 0, r < 5, wd, ht, $urandom_range(0, 99) < 70,
               $urandom_range(0, 255), $urandom_range(0, 99) < 30);
      end
      idle(3, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
